sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Central scheduler for the SDRAM controller. It shares the single SDRAM command/address/data bus between four sequencers: init, auto-refresh, burst-write and burst-read.
- After initialisation it grants one sequencer at a time. Priority is refresh first; write and read share round-robin.
- It drives the granted sequencer's cmd/ba/addr onto the pins and holds NOP at all other times.
- It sits between the sequencer modules and the top-level SDRAM pins.

Parameters:
- ADDR_W, 13, SDRAM row/column address width
- BA_W, 2, bank address width
- DQ_W, 16, data bus width

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  synchronous reset, active-high
- init_end  in  1  init sequence complete (level, stays high)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_ba  in  BA_W  init bank
- init_addr  in  ADDR_W  init address
- aref_req  in  1  refresh timer request (level, held until serviced)
- aref_end  in  1  refresh done pulse
- aref_cmd/aref_ba/aref_addr  in  4/BA_W/ADDR_W  refresh sequencer bus
- wr_req  in  1  write-side FIFO has a burst pending (level)
- wr_end  in  1  write burst done pulse
- wr_cmd/wr_ba/wr_addr  in  4/BA_W/ADDR_W  write sequencer bus
- wr_sdram_en  in  1  write sequencer drives DQ
- wr_sdram_data  in  DQ_W  write data
- rd_req  in  1  read burst pending (level)
- rd_end  in  1  read burst done pulse
- rd_cmd/rd_ba/rd_addr  in  4/BA_W/ADDR_W  read sequencer bus
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  BA_W  bank pins
- sdram_addr  out  ADDR_W  address pins
- sdram_dq_out  out  DQ_W  DQ drive value
- sdram_dq_oe  out  1  DQ output enable

Behaviour:
- State register with five states: ARB_INIT, ARB_IDLE, ARB_AREF, ARB_WRITE, ARB_READ.
- Reset (sys_rst high at a clock edge):
  - state goes to ARB_INIT; last_grant goes to READ, so the first contested grant goes to write.
  - While sys_rst is high, outputs are forced regardless of state: cmd = NOP 4'b0111, ba = all ones, addr = all ones, sdram_cke = 0, all *_en = 0, sdram_dq_oe = 0, sdram_dq_out = 0.
  - Reset mid-operation behaves identically: the grant drops in the next cycle and the sequencer is reset by the same sys_rst.
- sdram_cke = 1 whenever sys_rst is low.
- ARB_INIT:
  - pins = init_cmd/init_ba/init_addr.
  - go to ARB_IDLE on the cycle after init_end is first sampled high.
- ARB_IDLE decision, evaluated every cycle:
  - aref_req → ARB_AREF.
  - else wr_req & rd_req → the side opposite last_grant.
  - else wr_req → ARB_WRITE.
  - else rd_req → ARB_READ.
  - else stay in ARB_IDLE.
  - When ARB_WRITE or ARB_READ is chosen, last_grant updates on the same edge.
- ARB_AREF, ARB_WRITE, ARB_READ:
  - pins = the granted sequencer's cmd/ba/addr.
  - Return to ARB_IDLE on the edge where the matching *_end is sampled high.
  - *_end pulses from non-granted sequencers are ignored in every state.
- Grant outputs are decoded combinationally from the state register only (glitch-free):
  - aref_en = (state==ARB_AREF), wr_en = (state==ARB_WRITE), rd_en = (state==ARB_READ).
  - Consequence: the grant falls in the same cycle the sequencer returns to its idle, so no double start.
- Minimum one ARB_IDLE cycle between operations; the pins carry NOP in that cycle. A request asserted in the same cycle as *_end is granted two cycles later.
- No preemption: a refresh request arriving mid-burst waits for wr_end/rd_end. Worst-case refresh latency = longest burst + 1 cycle.
- ARB_IDLE pins: NOP, ba all ones, addr all ones.
- Data path:
  - sdram_dq_oe = wr_sdram_en & (state==ARB_WRITE).
  - sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 0.
- Default/illegal state encoding → ARB_IDLE with NOP outputs.

Decomposition:
- Package sdram_pkg:
  - command localparams NOP 4'b0111, ACTIVE 4'b0011, READ 4'b0101, WRITE 4'b0100, B_TERM 4'b0110, PRECHARGE 4'b0010, AUTO_REF 4'b0001, LOAD_MODE 4'b0000;
  - arbiter state encoding (3 bits);
  - grant-side enum (WRITE/READ).
- One sub-module, sdram_arb_rr: a two-requester round-robin picker holding last_grant. Inputs wr_req, rd_req, take; outputs pick_wr, pick_rd.

Test Plan:
- Reset then init: hold sys_rst 3 cycles, drive init_cmd=4'b0010 and init_end high at cycle 10 → pins show NOP with cke=0 during reset, 4'b0010 while in ARB_INIT, ARB_IDLE one cycle after init_end, all grants 0.
- Single read: rd_req=1 in ARB_IDLE → rd_en=1 next cycle; pins follow rd_cmd (ACTIVE, READ, B_TERM); rd_end pulse → rd_en=0 next cycle, pins NOP.
- Priority: aref_req, wr_req and rd_req all high in the same cycle in ARB_IDLE → aref_en first. After aref_end: write (last_grant was READ from reset), then read.
- Round-robin: wr_req and rd_req held high for 4 bursts → grant order W,R,W,R, each separated by exactly one NOP cycle.
- No preemption: aref_req rises mid-write → wr_en stays high until wr_end; aref_en two cycles after wr_end. Stray rd_end during the write is ignored.
- Reset mid-write: sys_rst high while in ARB_WRITE with dq_oe=1 → next cycle wr_en=0, dq_oe=0, cmd NOP, state ARB_INIT.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command codes, arbiter state encoding and grant-side type.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] NOP       = 4'b0111;
  localparam logic [3:0] ACTIVE    = 4'b0011;
  localparam logic [3:0] READ      = 4'b0101;
  localparam logic [3:0] WRITE     = 4'b0100;
  localparam logic [3:0] B_TERM    = 4'b0110;
  localparam logic [3:0] PRECHARGE = 4'b0010;
  localparam logic [3:0] AUTO_REF  = 4'b0001;
  localparam logic [3:0] LOAD_MODE = 4'b0000;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_side_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - Sequencer-side buses, grants and SDRAM pins around the arbiter.
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DQ_W-1:0]   wr_sdram_data;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_out;
  logic              sdram_dq_oe;

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// rtl/sdram_arb_rr.sv - Two-way write/read round-robin picker remembering the last side served.
module sdram_arb_rr
  import sdram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic take,
  output logic pick_wr,
  output logic pick_rd
);

  grant_side_t last_grant;

  // Contested requests go to the side that was not served last.
  assign pick_wr = wr_req & (~rd_req | (last_grant == GNT_READ));
  assign pick_rd = rd_req & (~wr_req | (last_grant == GNT_WRITE));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_READ;
    end else if (take && pick_wr) begin
      last_grant <= GNT_WRITE;
    end else if (take && pick_rd) begin
      last_grant <= GNT_READ;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM bus scheduler: init, then refresh-first, write/read round-robin.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  sdram_arbit_if.slave  bus
);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              take;
  logic              pick_wr;
  logic              pick_rd;
  logic [3:0]        pin_cmd;
  logic [BA_W-1:0]   pin_ba;
  logic [ADDR_W-1:0] pin_addr;
  logic              dq_oe;
  logic [DQ_W-1:0]   dq_val;

  sdram_arb_rr u_rr (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_req  (bus.wr_req),
    .rd_req  (bus.rd_req),
    .take    (take),
    .pick_wr (pick_wr),
    .pick_rd (pick_rd)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ARB_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      ARB_INIT:  if (bus.init_end) next_state = ARB_IDLE;
      ARB_IDLE: begin
        if (bus.aref_req) begin
          next_state = ARB_AREF;
        end else begin
          take = 1'b1;
          if (pick_wr) begin
            next_state = ARB_WRITE;
          end else if (pick_rd) begin
            next_state = ARB_READ;
          end
        end
      end
      ARB_AREF:  if (bus.aref_end) next_state = ARB_IDLE;
      ARB_WRITE: if (bus.wr_end) next_state = ARB_IDLE;
      ARB_READ:  if (bus.rd_end) next_state = ARB_IDLE;
      default:   next_state = ARB_IDLE;
    endcase
  end

  // Pin mux; reset overrides whatever the state register holds.
  always_comb begin
    pin_cmd  = NOP;
    pin_ba   = '1;
    pin_addr = '1;
    if (!sys_rst) begin
      case (state)
        ARB_INIT: begin
          pin_cmd  = bus.init_cmd;
          pin_ba   = bus.init_ba;
          pin_addr = bus.init_addr;
        end
        ARB_AREF: begin
          pin_cmd  = bus.aref_cmd;
          pin_ba   = bus.aref_ba;
          pin_addr = bus.aref_addr;
        end
        ARB_WRITE: begin
          pin_cmd  = bus.wr_cmd;
          pin_ba   = bus.wr_ba;
          pin_addr = bus.wr_addr;
        end
        ARB_READ: begin
          pin_cmd  = bus.rd_cmd;
          pin_ba   = bus.rd_ba;
          pin_addr = bus.rd_addr;
        end
        default: begin
          pin_cmd  = NOP;
          pin_ba   = '1;
          pin_addr = '1;
        end
      endcase
    end
  end

  assign dq_oe  = ~sys_rst & bus.wr_sdram_en & (state == ARB_WRITE);
  assign dq_val = dq_oe ? bus.wr_sdram_data : '0;

  assign bus.aref_en      = ~sys_rst & (state == ARB_AREF);
  assign bus.wr_en        = ~sys_rst & (state == ARB_WRITE);
  assign bus.rd_en        = ~sys_rst & (state == ARB_READ);
  assign bus.sdram_cke    = ~sys_rst;
  assign bus.sdram_cs_n   = pin_cmd[3];
  assign bus.sdram_ras_n  = pin_cmd[2];
  assign bus.sdram_cas_n  = pin_cmd[1];
  assign bus.sdram_we_n   = pin_cmd[0];
  assign bus.sdram_ba     = pin_ba;
  assign bus.sdram_addr   = pin_addr;
  assign bus.sdram_dq_oe  = dq_oe;
  assign bus.sdram_dq_out = dq_val;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - Self-checking bench for sdram_arbit against a bus-ownership model.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int M_INIT = 0;
  localparam int M_IDLE = 1;
  localparam int M_AREF = 2;
  localparam int M_WR   = 3;
  localparam int M_RD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbit_if bus();

  sdram_arbit dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Who owns the SDRAM bus, and whether write was the most recent data side served.
  int owner    = M_INIT;
  bit wr_was_last = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      owner = M_INIT;
      wr_was_last = 1'b0;
    end else if (owner == M_INIT) begin
      if (bus.init_end) owner = M_IDLE;
    end else if (owner == M_IDLE) begin
      if (bus.aref_req) owner = M_AREF;
      else if (bus.wr_req && !(bus.rd_req && wr_was_last)) begin
        owner = M_WR;
        wr_was_last = 1'b1;
      end else if (bus.rd_req) begin
        owner = M_RD;
        wr_was_last = 1'b0;
      end
    end else if ((owner == M_AREF && bus.aref_end) || (owner == M_WR && bus.wr_end) ||
                 (owner == M_RD && bus.rd_end)) begin
      owner = M_IDLE;
    end
  end

  function automatic logic [39:0] expect_vec();
    logic [3:0]  c = NOP;
    logic [1:0]  b = 2'b11;
    logic [12:0] a = 13'h1fff;
    logic        oe;
    if (rst) return {3'b000, 1'b0, NOP, 2'b11, 13'h1fff, 1'b0, 16'h0000};
    if (owner == M_INIT) begin c = bus.init_cmd; b = bus.init_ba; a = bus.init_addr; end
    if (owner == M_AREF) begin c = bus.aref_cmd; b = bus.aref_ba; a = bus.aref_addr; end
    if (owner == M_WR)   begin c = bus.wr_cmd;   b = bus.wr_ba;   a = bus.wr_addr;   end
    if (owner == M_RD)   begin c = bus.rd_cmd;   b = bus.rd_ba;   a = bus.rd_addr;   end
    oe = bus.wr_sdram_en && owner == M_WR;
    return {owner == M_AREF, owner == M_WR, owner == M_RD, 1'b1, c, b, a, oe,
            oe ? bus.wr_sdram_data : 16'h0000};
  endfunction

  function automatic logic [39:0] actual_vec();
    return {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n,
            bus.sdram_cas_n, bus.sdram_we_n, bus.sdram_ba, bus.sdram_addr, bus.sdram_dq_oe,
            bus.sdram_dq_out};
  endfunction

  always @(negedge clk) begin
    logic [39:0] act;
    logic [39:0] req;
    act = actual_vec();
    req = expect_vec();
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL model_cycle cyc=%0d actual=%h required=%h", cyc, act, req);
    end
  end

  function automatic logic [3:0] pins();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int side, input logic [3:0] c, input logic e);
    case (side)
      M_AREF:  begin bus.aref_cmd = c; bus.aref_end = e; end
      M_WR:    begin bus.wr_cmd = c;   bus.wr_end = e;   end
      default: begin bus.rd_cmd = c;   bus.rd_end = e;   end
    endcase
  endtask

  // Drives one sequencer burst of len cycles; *_end is pulsed on the final cycle.
  task automatic run_burst(input int side, input int len);
    for (int i = 0; i < len; i++) begin
      logic [3:0] c;
      if (side == M_AREF) c = (i == 0) ? AUTO_REF : NOP;
      else c = (i == 0) ? ACTIVE : (i == 1) ? ((side == M_WR) ? WRITE : READ) : B_TERM;
      set_cmd(side, c, i == len - 1);
      if (side == M_WR) begin
        bus.wr_sdram_en = (i == 1);
        bus.wr_sdram_data = 16'hC000 + 16'(i);
      end
      tick();
    end
    set_cmd(side, NOP, 1'b0);
    bus.wr_sdram_en = 1'b0;
  endtask

  task automatic wait_grant(output int who, output int waited);
    who = -1;
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.aref_en) who = M_AREF;
      else if (bus.wr_en) who = M_WR;
      else if (bus.rd_en) who = M_RD;
      if (who != -1) break;
      tick();
      waited++;
    end
    if (who == -1) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout cyc=%0d actual=none required=grant", cyc);
    end
  endtask

  initial begin
    int who;
    int waited;
    bus.init_end = 1'b0; bus.init_cmd = PRECHARGE; bus.init_ba = 2'd0; bus.init_addr = 13'h0400;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = NOP;
    bus.aref_ba = 2'd1; bus.aref_addr = 13'h00AA;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = NOP;
    bus.wr_ba = 2'd2; bus.wr_addr = 13'h0111;
    bus.wr_sdram_en = 1'b0; bus.wr_sdram_data = 16'h0000;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = NOP;
    bus.rd_ba = 2'd3; bus.rd_addr = 13'h0222;

    // Reset held for three edges, then init runs until init_end at cycle 10.
    tick();
    chk("rst_cke", 32'(bus.sdram_cke), 32'd0);
    chk("rst_cmd", 32'(pins()), 32'(NOP));
    chk("rst_grants", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("init_cmd", 32'(pins()), 32'h2);
    chk("init_cke", 32'(bus.sdram_cke), 32'd1);
    repeat (6) tick();
    bus.init_end = 1'b1;
    tick();
    chk("idle_cmd", 32'(pins()), 32'(NOP));
    chk("idle_addr", 32'(bus.sdram_addr), 32'h1fff);
    chk("idle_ba", 32'(bus.sdram_ba), 32'h3);
    chk("idle_grants", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'd0);

    // Single read.
    bus.rd_req = 1'b1;
    tick();
    chk("rd_grant", 32'(bus.rd_en), 32'd1);
    bus.rd_req = 1'b0;
    bus.rd_cmd = ACTIVE;
    #1;
    chk("rd_pin_cmd", 32'(pins()), 32'(ACTIVE));
    chk("rd_pin_addr", 32'(bus.sdram_addr), 32'h0222);
    run_burst(M_RD, 3);
    chk("rd_release", 32'(bus.rd_en), 32'd0);
    chk("rd_release_cmd", 32'(pins()), 32'(NOP));

    // Priority: refresh, then write, then read.
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    chk("prio_aref", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'b100);
    run_burst(M_AREF, 2);
    bus.aref_req = 1'b0;
    wait_grant(who, waited);
    chk("prio_second_wr", 32'(who), 32'(M_WR));
    bus.wr_req = 1'b0;
    run_burst(M_WR, 3);
    wait_grant(who, waited);
    chk("prio_third_rd", 32'(who), 32'(M_RD));
    bus.rd_req = 1'b0;
    run_burst(M_RD, 3);

    // Round-robin with both sides held: W,R,W,R with one NOP cycle between.
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_gap_cmd", 32'(pins()), 32'(NOP));
      wait_grant(who, waited);
      chk("rr_order", 32'(who), (k % 2 == 0) ? 32'(M_WR) : 32'(M_RD));
      chk("rr_gap", 32'(waited), 32'd1);
      run_burst(who, 3);
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    tick();

    // No preemption: refresh and a stray rd_end arrive mid-write.
    bus.wr_req = 1'b1;
    tick();
    chk("np_wr_grant", 32'(bus.wr_en), 32'd1);
    bus.wr_req = 1'b0;
    set_cmd(M_WR, ACTIVE, 1'b0);
    bus.aref_req = 1'b1;
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    chk("np_wr_hold", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'b010);
    set_cmd(M_WR, WRITE, 1'b0);
    bus.wr_sdram_en = 1'b1;
    bus.wr_sdram_data = 16'h5A5A;
    #1;
    chk("np_dq_oe", 32'(bus.sdram_dq_oe), 32'd1);
    chk("np_dq_out", 32'(bus.sdram_dq_out), 32'h5A5A);
    tick();
    bus.wr_sdram_en = 1'b0;
    set_cmd(M_WR, B_TERM, 1'b1);
    tick();
    set_cmd(M_WR, NOP, 1'b0);
    chk("np_idle_gap", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'd0);
    chk("np_dq_off", 32'(bus.sdram_dq_out), 32'd0);
    tick();
    chk("np_aref_late", 32'(bus.aref_en), 32'd1);
    run_burst(M_AREF, 2);
    bus.aref_req = 1'b0;
    tick();

    // Reset in the middle of a write data phase.
    bus.wr_req = 1'b1;
    tick();
    chk("rw_wr_grant", 32'(bus.wr_en), 32'd1);
    bus.wr_req = 1'b0;
    set_cmd(M_WR, WRITE, 1'b0);
    bus.wr_sdram_en = 1'b1;
    bus.wr_sdram_data = 16'hBEEF;
    #1;
    chk("rw_dq_oe_before", 32'(bus.sdram_dq_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_forced_cmd", 32'(pins()), 32'(NOP));
    chk("rw_forced_cke", 32'(bus.sdram_cke), 32'd0);
    tick();
    chk("rw_wr_drop", 32'(bus.wr_en), 32'd0);
    chk("rw_dq_drop", 32'(bus.sdram_dq_oe), 32'd0);
    rst = 1'b0;
    bus.wr_sdram_en = 1'b0;
    set_cmd(M_WR, NOP, 1'b0);
    #1;
    chk("rw_back_in_init", 32'(pins()), 32'h2);
    tick();
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    chk("rw_first_after_rst", 32'({bus.aref_en, bus.wr_en, bus.rd_en}), 32'b010);
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    run_burst(M_WR, 3);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
